// File: rtl/buffer_reader.sv
// -----------------------------------------------------------------------------
// buffer_reader
//
// Read-side consumer for the dual-clock data buffer, running in the display
// clock domain. When enabled and the buffer holds data, it pops one word,
// presents it on data_out for a programmable dwell time, and then decides
// whether to pop again. A flush input shortens every hold to a single cycle
// so the buffer can be drained quickly after a stop.
//
// Parameters:
//   DATA_W  width of buffer words and of data_out
//   DWELL   hold cycles per word (0 is treated as 1)
//   CNT_W   width of the consumed-word counter
//
// Ports:
//   clk         read-side clock of the buffer
//   rst         asynchronous, active-low reset
//   en          level, allows new reads to start
//   flush       level, forces a dwell of one cycle
//   empty       buffer empty flag, synchronous to clk
//   rd_data     buffer read data, valid the cycle after rd_en
//   rd_en       one-cycle pop request to the buffer
//   data_out    last word consumed, held stable between updates
//   data_valid  one-cycle strobe on each data_out update
//   parity      XOR reduction of data_out (1 = odd number of ones)
//   word_cnt    words consumed since reset, wraps modulo 2^CNT_W
//   busy        high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module buffer_reader #(
  parameter int DATA_W = 16,
  parameter int DWELL  = 4,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  // A dwell of zero would leave no hold cycle at all; clamp it to one.
  localparam int DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
  localparam int DCNT_W    = $clog2(DWELL_EFF + 1);
  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL_EFF - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Even/odd parity of a buffer word: 1 when the number of ones is odd.
  function automatic logic calc_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  logic [1:0]        state_q,  state_d;
  logic [DCNT_W-1:0] dwell_q,  dwell_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              parity_q, parity_d;
  logic              valid_q,  valid_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              rd_en_q,  rd_en_d;
  logic              busy_q,   busy_d;

  logic              can_start_s;
  logic              hold_last_s;

  // A new pop may start only when enabled and the buffer has data; empty is
  // only looked at in IDLE and on the last hold cycle, where this is used.
  assign can_start_s = en & ~empty;

  // Last hold cycle: dwell count reached, or flush cuts the hold short.
  assign hold_last_s = (state_q == S_HOLD) && (flush || (dwell_q == DWELL_LAST));

  // Next-state and output-register computation for the read FSM.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    data_d   = data_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (can_start_s) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end

      // The pop request is a single cycle; read data is ready in LOAD.
      S_REQ: begin
        state_d = S_LOAD;
      end

      // Capture the popped word; visible outputs change only on this edge.
      S_LOAD: begin
        data_d   = rd_data;
        parity_d = calc_parity(rd_data);
        cnt_d    = cnt_q + CNT_W'(1);
        valid_d  = 1'b1;
        dwell_d  = {DCNT_W{1'b0}};
        state_d  = S_HOLD;
      end

      S_HOLD: begin
        dwell_d = dwell_q + DCNT_W'(1);
        if (hold_last_s) begin
          if (can_start_s) begin
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d = S_IDLE;
        dwell_d = {DCNT_W{1'b0}};
      end
    endcase

    // Decoded from the next state so the registered copies line up with
    // the state register itself.
    rd_en_d = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
  end

  // FSM state and dwell counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dwell_q <= {DCNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // Output word, parity, strobe and consumed-word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= {DATA_W{1'b0}};
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      data_q   <= data_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  // State-decoded status outputs, held in flops for glitch-free pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign data_out   = data_q;
  assign parity     = parity_q;
  assign data_valid = valid_q;
  assign word_cnt   = cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_buffer_reader.sv
module tb_buffer_reader;

  localparam int DATA_W = 16;
  localparam int DWELL  = 4;
  localparam int CNT_W  = 6;
  localparam int PERIOD = DWELL + 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic              flush;
  logic              empty = 1'b1;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity;
  logic [CNT_W-1:0]  word_cnt;
  logic              busy;

  int n_cmp;
  int n_err;
  int cyc = 0;
  int model_cnt;
  int busy_cnt;

  logic [DATA_W-1:0] wbuf[$];
  logic [DATA_W-1:0] sent[$];
  int                rd_cyc[$];
  int                val_cyc[$];
  logic [DATA_W-1:0] val_data[$];
  logic              val_par[$];
  logic [CNT_W-1:0]  val_cnt[$];

  buffer_reader #(.DATA_W(DATA_W), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .empty(empty),
    .rd_data(rd_data), .rd_en(rd_en), .data_out(data_out),
    .data_valid(data_valid), .parity(parity), .word_cnt(word_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model and event log, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_cyc.push_back(cyc);
      if (wbuf.size() > 0) rd_data = wbuf.pop_front();
      else rd_data = '0;
    end
    if (data_valid === 1'b1) begin
      val_cyc.push_back(cyc);
      val_data.push_back(data_out);
      val_par.push_back(parity);
      val_cnt.push_back(word_cnt);
    end
    if (busy === 1'b1) busy_cnt++;
    empty = (wbuf.size() == 0);
  end

  function automatic logic exp_parity(input logic [DATA_W-1:0] w);
    return 1'($countones(w) % 2);
  endfunction

  task automatic push_word(input logic [DATA_W-1:0] w);
    wbuf.push_back(w);
    sent.push_back(w);
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); val_cyc.delete(); val_data.delete();
    val_par.delete(); val_cnt.delete();
    busy_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    int rel;
    logic [DATA_W-1:0] w;
    en = 1'b1;
    push_word(DATA_W'($urandom));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rd_en, data_valid, parity, busy, word_cnt, data_out} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: rd_en=%b valid=%b par=%b busy=%b cnt=%0d data=%h, expected all 0",
                 rd_en, data_valid, parity, busy, word_cnt, data_out);
      end
    end
    @(posedge clk); #2;
    clear_logs();
    rel = cyc;
    rst = 1'b1;
    step(12);
    n_cmp++;
    if (rd_cyc.size() != 1) begin
      n_err++; $display("FAIL reset_rd_count: got %0d expected 1", rd_cyc.size());
    end else begin
      n_cmp++;
      if (rd_cyc[0] != rel + 1) begin
        n_err++; $display("FAIL reset_first_rd: got cycle %0d expected %0d", rd_cyc[0], rel + 1);
      end
    end
    n_cmp++;
    if (val_data.size() != 1) begin
      n_err++; $display("FAIL reset_val_count: got %0d expected 1", val_data.size());
    end else begin
      w = sent.pop_front(); model_cnt++;
      n_cmp++;
      if (val_data[0] !== w || val_par[0] !== exp_parity(w) || val_cnt[0] !== CNT_W'(model_cnt % (1 << CNT_W))) begin
        n_err++; $display("FAIL reset_word: got %h/%b/%0d expected %h/%b/%0d",
                          val_data[0], val_par[0], val_cnt[0], w, exp_parity(w), model_cnt);
      end
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] w;
    clear_logs();
    push_word(16'h00A5);
    step(14);
    n_cmp++;
    if (rd_cyc.size() != 1 || val_cyc.size() != 1) begin
      n_err++; $display("FAIL single_counts: rd=%0d valid=%0d expected 1/1", rd_cyc.size(), val_cyc.size());
    end else begin
      w = sent.pop_front(); model_cnt++;
      n_cmp++;
      if (val_cyc[0] - rd_cyc[0] != 2) begin
        n_err++; $display("FAIL single_latency: got %0d expected 2", val_cyc[0] - rd_cyc[0]);
      end
      n_cmp++;
      if (val_data[0] !== 16'h00A5 || val_par[0] !== 1'b0) begin
        n_err++; $display("FAIL single_data: got %h/%b expected 00a5/0", val_data[0], val_par[0]);
      end
      n_cmp++;
      if (val_cnt[0] !== CNT_W'(model_cnt % (1 << CNT_W))) begin
        n_err++; $display("FAIL single_cnt: got %0d expected %0d", val_cnt[0], model_cnt);
      end
    end
    n_cmp++;
    if (busy_cnt != PERIOD || busy !== 1'b0) begin
      n_err++; $display("FAIL single_busy: got %0d cycles (busy now %b) expected %0d (0)", busy_cnt, busy, PERIOD);
    end
  endtask

  task automatic test_stream(input bit directed);
    int n;
    logic [DATA_W-1:0] w;
    clear_logs();
    if (directed) begin
      n = 3;
      push_word(16'h0001); push_word(16'h0003); push_word(16'h0007);
    end else begin
      n = $urandom_range(4, 8);
      for (int i = 0; i < n; i++) push_word(DATA_W'($urandom));
    end
    step(n * PERIOD + 8);
    n_cmp++;
    if (rd_cyc.size() != n || val_cyc.size() != n) begin
      n_err++; $display("FAIL stream_counts: rd=%0d valid=%0d expected %0d", rd_cyc.size(), val_cyc.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = sent.pop_front(); model_cnt++;
        if (i > 0) begin
          n_cmp++;
          if (rd_cyc[i] - rd_cyc[i-1] != PERIOD) begin
            n_err++; $display("FAIL stream_period: word %0d got %0d expected %0d", i, rd_cyc[i] - rd_cyc[i-1], PERIOD);
          end
        end
        n_cmp++;
        if (val_cyc[i] - rd_cyc[i] != 2) begin
          n_err++; $display("FAIL stream_latency: word %0d got %0d expected 2", i, val_cyc[i] - rd_cyc[i]);
        end
        n_cmp++;
        if (val_data[i] !== w || val_par[i] !== exp_parity(w) || val_cnt[i] !== CNT_W'(model_cnt % (1 << CNT_W))) begin
          n_err++; $display("FAIL stream_word: word %0d got %h/%b/%0d expected %h/%b/%0d",
                            i, val_data[i], val_par[i], val_cnt[i], w, exp_parity(w), model_cnt % (1 << CNT_W));
        end
      end
    end
    n_cmp++;
    if (word_cnt !== CNT_W'(model_cnt % (1 << CNT_W))) begin
      n_err++; $display("FAIL stream_final_cnt: got %0d expected %0d", word_cnt, model_cnt % (1 << CNT_W));
    end
  endtask

  task automatic test_flush();
    bit got;
    logic [DATA_W-1:0] w;
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(DATA_W'($urandom));
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL flush_first_valid: got timeout expected strobe");
    end
    @(posedge clk); #2;
    flush = 1'b1;
    step(20);
    flush = 1'b0;
    n_cmp++;
    if (rd_cyc.size() != 4 || val_cyc.size() != 4) begin
      n_err++; $display("FAIL flush_counts: rd=%0d valid=%0d expected 4", rd_cyc.size(), val_cyc.size());
    end else begin
      n_cmp++;
      if (rd_cyc[1] != val_cyc[0] + 2) begin
        n_err++; $display("FAIL flush_cut_hold: got rd at %0d expected %0d", rd_cyc[1], val_cyc[0] + 2);
      end
      for (int i = 2; i < 4; i++) begin
        n_cmp++;
        if (rd_cyc[i] - rd_cyc[i-1] != 3) begin
          n_err++; $display("FAIL flush_period: word %0d got %0d expected 3", i, rd_cyc[i] - rd_cyc[i-1]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        w = sent.pop_front(); model_cnt++;
        n_cmp++;
        if (val_data[i] !== w || val_cnt[i] !== CNT_W'(model_cnt % (1 << CNT_W))) begin
          n_err++; $display("FAIL flush_word: word %0d got %h/%0d expected %h/%0d", i, val_data[i], val_cnt[i], w, model_cnt);
        end
      end
    end
  endtask

  task automatic test_disable();
    bit got;
    logic [DATA_W-1:0] w;
    clear_logs();
    push_word(DATA_W'($urandom)); push_word(DATA_W'($urandom));
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin got = 1'b1; break; end
    end
    en = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL disable_rd_seen: got timeout expected rd_en");
    end
    step(15);
    n_cmp++;
    if (rd_cyc.size() != 1 || val_data.size() != 1 || empty !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL disable_stop: rd=%0d valid=%0d empty=%b busy=%b expected 1/1/0/0",
                        rd_cyc.size(), val_data.size(), empty, busy);
    end else begin
      w = sent.pop_front(); model_cnt++;
      n_cmp++;
      if (val_data[0] !== w || val_cnt[0] !== CNT_W'(model_cnt % (1 << CNT_W))) begin
        n_err++; $display("FAIL disable_word: got %h/%0d expected %h/%0d", val_data[0], val_cnt[0], w, model_cnt);
      end
    end
    clear_logs();
    en = 1'b1;
    step(12);
    n_cmp++;
    if (val_data.size() != 1) begin
      n_err++; $display("FAIL disable_resume: got %0d words expected 1", val_data.size());
    end else begin
      w = sent.pop_front(); model_cnt++;
      n_cmp++;
      if (val_data[0] !== w || val_par[0] !== exp_parity(w)) begin
        n_err++; $display("FAIL disable_resume_word: got %h/%b expected %h/%b", val_data[0], val_par[0], w, exp_parity(w));
      end
    end
  endtask

  task automatic test_wrap();
    int k;
    logic [DATA_W-1:0] w;
    clear_logs();
    k = (1 << CNT_W) - (model_cnt % (1 << CNT_W));
    flush = 1'b1;
    for (int i = 0; i < k; i++) push_word(DATA_W'($urandom));
    step(3 * k + 10);
    flush = 1'b0;
    n_cmp++;
    if (val_data.size() != k) begin
      n_err++; $display("FAIL wrap_count: got %0d expected %0d", val_data.size(), k);
    end else begin
      for (int i = 0; i < k; i++) begin
        w = sent.pop_front(); model_cnt++;
        n_cmp++;
        if (val_data[i] !== w || val_par[i] !== exp_parity(w) || val_cnt[i] !== CNT_W'(model_cnt % (1 << CNT_W))) begin
          n_err++; $display("FAIL wrap_word: word %0d got %h/%b/%0d expected %h/%b/%0d",
                            i, val_data[i], val_par[i], val_cnt[i], w, exp_parity(w), model_cnt % (1 << CNT_W));
        end
      end
    end
    n_cmp++;
    if (word_cnt !== '0) begin
      n_err++; $display("FAIL wrap_zero: got %0d expected 0", word_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    logic [DATA_W-1:0] w;
    clear_logs();
    push_word(DATA_W'($urandom)); push_word(DATA_W'($urandom));
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL areset_rd_seen: got timeout expected rd_en");
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rd_en, data_valid, parity, busy, word_cnt, data_out} !== '0) begin
      n_err++; $display("FAIL areset_immediate: rd_en=%b valid=%b par=%b busy=%b cnt=%0d data=%h expected all 0",
                        rd_en, data_valid, parity, busy, word_cnt, data_out);
    end
    void'(sent.pop_front());
    model_cnt = 0;
    clear_logs();
    step(4);
    n_cmp++;
    if (rd_cyc.size() != 0 || val_data.size() != 0 || empty !== 1'b0) begin
      n_err++; $display("FAIL areset_quiet: rd=%0d valid=%0d empty=%b expected 0/0/0", rd_cyc.size(), val_data.size(), empty);
    end
    rst = 1'b1;
    step(12);
    n_cmp++;
    if (val_data.size() != 1) begin
      n_err++; $display("FAIL areset_after: got %0d words expected 1", val_data.size());
    end else begin
      w = sent.pop_front(); model_cnt++;
      n_cmp++;
      if (val_data[0] !== w || val_cnt[0] !== CNT_W'(model_cnt)) begin
        n_err++; $display("FAIL areset_after_word: got %h/%0d expected %h/%0d", val_data[0], val_cnt[0], w, model_cnt);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; model_cnt = 0; busy_cnt = 0;
    en = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_single();
    test_stream(1'b1);
    test_stream(1'b0);
    test_flush();
    test_disable();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
